// File: rtl/fetch_decode_stage_pkg.sv
// Shared RV32I pipeline definitions: widths, NOP encoding, opcode constants
// and a PC alignment helper used by fetch, hazard and decode logic.
package fetch_decode_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 7;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    // Instruction fetch is word-granular; drop the byte offset of a target.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_decode_stage_pc_reg.sv
// Program counter register with reset value and hold enable; the next-PC
// value is selected by the fetch stage and presented on load_pc.
module fetch_decode_stage_pc_reg
    import fetch_decode_stage_pkg::XLEN;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_en,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc_q
);

    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = load_pc;
        if (hold_en) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/DE pipeline register: owns the PC, drives the
// synchronous instruction memory and applies load-use stalls and EX redirects.
module fetch_decode_stage
    import fetch_decode_stage_pkg::XLEN;
    import fetch_decode_stage_pkg::PC_STEP;
    import fetch_decode_stage_pkg::word_align;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_decode_stage_pkg::NOP_INSTR
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load_use_haz,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_rden,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] de_pc,
    output logic [XLEN-1:0] de_pc4,
    output logic [XLEN-1:0] de_ir,
    output logic            de_valid,
    output logic            de_ex_bubble,
    output logic [XLEN-1:0] fetch_cnt,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] flush_cnt
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_load;
    logic            pc_hold;
    logic            stall;
    logic            accept;

    logic [XLEN-1:0] de_pc_d,     de_pc_q;
    logic [XLEN-1:0] de_pc4_d,    de_pc4_q;
    logic            de_valid_d,  de_valid_q;
    logic [XLEN-1:0] fetch_cnt_d, fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_d, stall_cnt_q;
    logic [XLEN-1:0] flush_cnt_d, flush_cnt_q;

    fetch_decode_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (CLK),
        .rst     (RST),
        .hold_en (pc_hold),
        .load_pc (pc_load),
        .pc_q    (pc_q)
    );

    // Next-PC selection; a redirect overrides a simultaneous stall.
    always_comb begin
        stall   = load_use_haz && !redirect;
        accept  = !load_use_haz && !redirect;
        pc_hold = stall;
        pc_load = pc_q + PC_STEP;
        if (redirect) begin
            pc_load = word_align(redirect_pc);
        end
    end

    // IF/DE slot update and event counters.
    always_comb begin
        de_pc_d     = de_pc_q;
        de_valid_d  = de_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            de_pc_d     = pc_q;
            de_valid_d  = 1'b0;
            flush_cnt_d = flush_cnt_q + XLEN'(1);
        end else if (load_use_haz) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end else begin
            de_pc_d     = pc_q;
            de_valid_d  = 1'b1;
        end
        if (accept) begin
            fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        end
        de_pc4_d = de_pc_d + PC_STEP;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            de_pc_q     <= RESET_PC;
            de_pc4_q    <= RESET_PC + PC_STEP;
            de_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            de_pc_q     <= de_pc_d;
            de_pc4_q    <= de_pc4_d;
            de_valid_q  <= de_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Memory output freezes while rden is low, so de_ir needs no local copy.
    assign imem_addr    = pc_q;
    assign imem_rden    = !load_use_haz || redirect;
    assign de_ir        = de_valid_q ? imem_data : NOP_INSTR;
    assign de_ex_bubble = load_use_haz || redirect || !de_valid_q;

    assign de_pc     = de_pc_q;
    assign de_pc4    = de_pc4_q;
    assign de_valid  = de_valid_q;
    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: two instances (default reset PC and
// a wrapping reset PC) fed by small synchronous instruction memory models.
module tb_fetch_decode_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use_haz;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] imem_addr, imem_data, de_pc, de_pc4, de_ir;
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
    logic        imem_rden, de_valid, de_ex_bubble;

    logic [31:0] b_imem_addr, b_imem_data, b_de_pc, b_de_pc4, b_de_ir;
    logic [31:0] b_fetch_cnt, b_stall_cnt, b_flush_cnt;
    logic        b_imem_rden, b_de_valid, b_de_ex_bubble;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_decode_stage u_dut (
        .CLK (clk), .RST (rst),
        .load_use_haz (load_use_haz), .redirect (redirect), .redirect_pc (redirect_pc),
        .imem_addr (imem_addr), .imem_rden (imem_rden), .imem_data (imem_data),
        .de_pc (de_pc), .de_pc4 (de_pc4), .de_ir (de_ir), .de_valid (de_valid),
        .de_ex_bubble (de_ex_bubble),
        .fetch_cnt (fetch_cnt), .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
    );

    fetch_decode_stage #(.RESET_PC (WRAP_PC)) u_dut_wrap (
        .CLK (clk), .RST (rst),
        .load_use_haz (load_use_haz), .redirect (redirect), .redirect_pc (redirect_pc),
        .imem_addr (b_imem_addr), .imem_rden (b_imem_rden), .imem_data (b_imem_data),
        .de_pc (b_de_pc), .de_pc4 (b_de_pc4), .de_ir (b_de_ir), .de_valid (b_de_valid),
        .de_ex_bubble (b_de_ex_bubble),
        .fetch_cnt (b_fetch_cnt), .stall_cnt (b_stall_cnt), .flush_cnt (b_flush_cnt)
    );

    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        return 32'hA500_0000 ^ addr;
    endfunction

    // Synchronous instruction memories: data one cycle after address, held when rden=0.
    always @(posedge clk) begin
        if (imem_rden)   imem_data   <= instr_at(imem_addr);
        if (b_imem_rden) b_imem_data <= instr_at(b_imem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_use_haz = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", imem_addr, 32'h0); end
        checks++; if ({de_pc, de_pc4} !== {32'h0, 32'h4}) begin errors++; $display("FAIL reset_de_pc: got %h/%h want 0/4", de_pc, de_pc4); end
        checks++; if ({de_valid, de_ex_bubble, imem_rden} !== 3'b011) begin errors++; $display("FAIL reset_flags: got v=%b bub=%b rden=%b want 0 1 1", de_valid, de_ex_bubble, imem_rden); end
        checks++; if (de_ir !== NOP) begin errors++; $display("FAIL reset_de_ir: got %h want %h", de_ir, NOP); end
        checks++; if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'h0) begin errors++; $display("FAIL reset_cnts: got %0d %0d %0d want 0 0 0", fetch_cnt, stall_cnt, flush_cnt); end
        checks++; if ({b_imem_addr, b_de_pc, b_de_pc4} !== {WRAP_PC, WRAP_PC, 32'h0}) begin errors++; $display("FAIL reset_wrap: got pc=%h de_pc=%h pc4=%h want fffffffc fffffffc 0", b_imem_addr, b_de_pc, b_de_pc4); end
    endtask

    task automatic test_no_hazard();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({de_pc, de_valid, de_ir} !== {exp_pc[i], 1'b1, instr_at(exp_pc[i])}) begin
                errors++;
                $display("FAIL run_slot%0d: got pc=%h v=%b ir=%h want pc=%h v=1 ir=%h", i, de_pc, de_valid, de_ir, exp_pc[i], instr_at(exp_pc[i]));
            end
            if (i == 0) begin
                checks++; if ({b_imem_addr, b_de_pc, b_de_pc4, b_de_valid} !== {32'h0, WRAP_PC, 32'h0, 1'b1}) begin errors++; $display("FAIL wrap_edge1: got pc=%h de_pc=%h pc4=%h v=%b", b_imem_addr, b_de_pc, b_de_pc4, b_de_valid); end
            end else if (i == 1) begin
                checks++; if ({b_imem_addr, b_de_pc} !== {32'h4, 32'h0}) begin errors++; $display("FAIL wrap_edge2: got pc=%h de_pc=%h want 4 0", b_imem_addr, b_de_pc); end
            end
        end
        checks++; if ({fetch_cnt, imem_addr, de_ex_bubble} !== {32'd3, 32'hC, 1'b0}) begin errors++; $display("FAIL run_totals: got fetch=%0d pc=%h bub=%b want 3 c 0", fetch_cnt, imem_addr, de_ex_bubble); end
    endtask

    task automatic test_stall();
        load_use_haz = 1'b1;
        #1;
        checks++; if ({imem_rden, de_ex_bubble} !== 2'b01) begin errors++; $display("FAIL stall_comb: got rden=%b bub=%b want 0 1", imem_rden, de_ex_bubble); end
        step();
        checks++; if ({de_pc, imem_addr, de_ir} !== {32'h8, 32'hC, instr_at(32'h8)}) begin errors++; $display("FAIL stall_hold: got de_pc=%h pc=%h ir=%h want 8 c %h", de_pc, imem_addr, de_ir, instr_at(32'h8)); end
        checks++; if ({stall_cnt, fetch_cnt} !== {32'd1, 32'd3}) begin errors++; $display("FAIL stall_cnt: got stall=%0d fetch=%0d want 1 3", stall_cnt, fetch_cnt); end
        load_use_haz = 1'b0;
        #1;
        checks++; if ({imem_rden, de_ex_bubble} !== 2'b10) begin errors++; $display("FAIL stall_release: got rden=%b bub=%b want 1 0", imem_rden, de_ex_bubble); end
        step();
        checks++; if ({de_pc, imem_addr, de_ir, fetch_cnt} !== {32'hC, 32'h10, instr_at(32'hC), 32'd4}) begin errors++; $display("FAIL stall_resume: got de_pc=%h pc=%h ir=%h fetch=%0d", de_pc, imem_addr, de_ir, fetch_cnt); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        #1;
        checks++; if ({imem_rden, de_ex_bubble} !== 2'b11) begin errors++; $display("FAIL redir_comb: got rden=%b bub=%b want 1 1", imem_rden, de_ex_bubble); end
        step();
        redirect = 1'b0;
        #1;
        checks++; if ({imem_addr, de_valid, de_ir, de_ex_bubble} !== {32'h100, 1'b0, NOP, 1'b1}) begin errors++; $display("FAIL redir_flush: got pc=%h v=%b ir=%h bub=%b want 100 0 %h 1", imem_addr, de_valid, de_ir, de_ex_bubble, NOP); end
        checks++; if ({flush_cnt, fetch_cnt} !== {32'd1, 32'd4}) begin errors++; $display("FAIL redir_cnt: got flush=%0d fetch=%0d want 1 4", flush_cnt, fetch_cnt); end
        step();
        checks++; if ({de_pc, de_pc4, de_valid, de_ir, imem_addr} !== {32'h100, 32'h104, 1'b1, instr_at(32'h100), 32'h104}) begin errors++; $display("FAIL redir_target: got de_pc=%h pc4=%h v=%b ir=%h pc=%h", de_pc, de_pc4, de_valid, de_ir, imem_addr); end
    endtask

    task automatic test_stall_and_redirect();
        load_use_haz = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        checks++; if (imem_rden !== 1'b1) begin errors++; $display("FAIL both_rden: got %b want 1", imem_rden); end
        step();
        load_use_haz = 1'b0; redirect = 1'b0;
        checks++; if ({imem_addr, de_valid, stall_cnt, flush_cnt, fetch_cnt} !== {32'h40, 1'b0, 32'd1, 32'd2, 32'd5}) begin errors++; $display("FAIL both_redir: got pc=%h v=%b stall=%0d flush=%0d fetch=%0d", imem_addr, de_valid, stall_cnt, flush_cnt, fetch_cnt); end
        step();
        checks++; if ({de_pc, de_valid, de_ir, fetch_cnt} !== {32'h40, 1'b1, instr_at(32'h40), 32'd6}) begin errors++; $display("FAIL both_target: got de_pc=%h v=%b ir=%h fetch=%0d", de_pc, de_valid, de_ir, fetch_cnt); end
    endtask

    task automatic test_back_to_back();
        load_use_haz = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({de_pc, imem_addr, de_ir} !== {32'h40, 32'h44, instr_at(32'h40)}) begin errors++; $display("FAIL b2b_hold%0d: got de_pc=%h pc=%h ir=%h", i, de_pc, imem_addr, de_ir); end
        end
        checks++; if ({stall_cnt, fetch_cnt} !== {32'd3, 32'd6}) begin errors++; $display("FAIL b2b_cnt: got stall=%0d fetch=%0d want 3 6", stall_cnt, fetch_cnt); end
        load_use_haz = 1'b0;
        step();
        checks++; if ({de_pc, de_ir, fetch_cnt} !== {32'h44, instr_at(32'h44), 32'd7}) begin errors++; $display("FAIL b2b_resume: got de_pc=%h ir=%h fetch=%0d", de_pc, de_ir, fetch_cnt); end
    endtask

    task automatic test_reset_during_stall();
        load_use_haz = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({imem_addr, de_pc, de_valid, de_ir} !== {32'h0, 32'h0, 1'b0, NOP}) begin errors++; $display("FAIL rst_stall_state: got pc=%h de_pc=%h v=%b ir=%h", imem_addr, de_pc, de_valid, de_ir); end
        checks++; if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'h0) begin errors++; $display("FAIL rst_stall_cnts: got %0d %0d %0d want 0 0 0", fetch_cnt, stall_cnt, flush_cnt); end
        checks++; if (b_imem_addr !== WRAP_PC) begin errors++; $display("FAIL rst_stall_wrap: got %h want %h", b_imem_addr, WRAP_PC); end
        load_use_haz = 1'b0;
        step();
        checks++; if ({de_pc, de_valid, fetch_cnt, imem_addr} !== {32'h0, 1'b1, 32'd1, 32'h4}) begin errors++; $display("FAIL rst_stall_resume: got de_pc=%h v=%b fetch=%0d pc=%h", de_pc, de_valid, fetch_cnt, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_stall();
        test_redirect();
        test_stall_and_redirect();
        test_back_to_back();
        test_reset_during_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
